// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage (master) and the wait-stated data memory (slave).
// Request fields are driven by the stage; completion, load data and stall come back from the memory.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack,
        input  err,
        input  stall
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack,
        output err,
        output stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated data memory for the MEM stage: one word access at a time, LATENCY wait
// cycles, registered load data, and a stall that holds the pipeline until completion.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic                r_we;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_ack;
    logic                r_err;
    logic                w_latch;
    logic                w_complete;
    logic                w_stall;
    logic                w_misaligned;
    logic                w_do_write;
    logic                w_do_read;
    logic [ADDR_W-1:0]   w_index;
    logic                w_unused_addr_hi;

    logic [31:0] r_mem [0:DEPTH-1];

    // Upper address bits do not select anything: the word index wraps modulo the depth.
    assign w_unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    assign w_index      = r_addr[ADDR_W+1:2];
    assign w_misaligned = (r_addr[1:0] != 2'b00);
    // Reset on the completing edge suppresses the access entirely.
    assign w_do_write   = w_complete &&  r_we && !w_misaligned && !rst;
    assign w_do_read    = w_complete && !r_we && !w_misaligned && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_latch) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr[ADDR_W+1:0];
                r_wdata <= bus.wdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        w_complete   = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_stall      = 1'b1;
                    w_latch      = 1'b1;
                    w_cnt_next   = 4'(LATENCY);
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_complete   = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            // req still belongs to the completing instruction here, so it is not looked at.
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[w_index] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (w_do_read) begin
            r_rdata <= r_mem[w_index];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= w_complete;
            r_err <= w_complete && w_misaligned;
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.stall = w_stall;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset corner cases, then random
// accesses checked against a word-array memory model with closed-form timing.
module tb_dmem_responder;
    localparam int LAT = 2;
    localparam int AW  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_responder_if bus();

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [0:(1<<AW)-1];
    logic [31:0] m_rdata;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory semantics only: misaligned accesses touch nothing, stores leave rdata alone.
    task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output bit exp_err);
        logic [AW-1:0] idx;
        idx     = addr[AW+1:2];
        exp_err = (addr[1:0] != 2'b00);
        if (!exp_err) begin
            if (we) m_mem[idx] = wd;
            else    m_rdata    = m_mem[idx];
        end
        exp_rd = m_rdata;
    endtask

    // Called just after a rising edge with the DUT idle; returns in the same phase, idle again.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_err);
        int          stalls;
        int          ackc;
        logic [31:0] got_rd;
        logic        got_err;
        stalls  = 0;
        ackc    = -1;
        got_rd  = 32'd0;
        got_err = 1'b0;
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ack) begin
                ackc    = c;
                got_rd  = bus.rdata;
                got_err = bus.err;
                check("stall_in_resp", {31'd0, bus.stall}, 32'd0);
                break;
            end
            if (bus.stall) stalls++;
            @(posedge clk); #1;
            // Scramble the request fields; only the values seen at acceptance matter.
            bus.we    = 1'($urandom);
            bus.addr  = $urandom;
            bus.wdata = $urandom;
        end
        if (ackc < 0) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("ack_cycle", ackc, LAT + 2);
            check("stall_cycles", stalls, LAT + 2);
            check("err", {31'd0, got_err}, {31'd0, exp_err});
            check("rdata", got_rd, exp_rd);
        end
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(negedge clk);
        check("ack_single", {31'd0, bus.ack}, 32'd0);
        check("stall_idle", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        $display("access we=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d ack_cycle=%0d",
                 we, addr, wd, got_rd, got_err, ackc);
    endtask

    initial begin
        logic [31:0] er;
        bit          ee;
        logic [31:0] a;
        logic [31:0] d;
        bit          w;

        tbl[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0044, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
        tbl[3] = '{1'b0, 32'h0000_0044, 32'h0000_0000, 32'h1111_1111, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_0042, 32'h7777_7777, 32'h1111_1111, 1'b1};
        tbl[5] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        tbl[6] = '{1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};

        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_ack", {31'd0, bus.ack}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        rst     = 1'b0;
        bus.req = 1'b0;
        m_rdata = 32'd0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            model(tbl[i].we, tbl[i].addr, tbl[i].wdata, er, ee);
            access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err);
        end

        // Reset lands on the completing edge of a store of 0 to 0x40.
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h0000_0040;
        bus.wdata = 32'h0000_0000;
        @(posedge clk); #1;
        bus.addr = 32'h0000_0044;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst     = 1'b1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        rst     = 1'b0;
        m_rdata = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_ack_after_rst", {31'd0, bus.ack}, 32'd0);
        end
        check("rdata_after_rst", bus.rdata, 32'd0);
        @(posedge clk); #1;
        model(1'b0, 32'h0000_0040, 32'd0, er, ee);
        access(1'b0, 32'h0000_0040, 32'd0, er, ee);
        model(1'b0, 32'h0000_0044, 32'd0, er, ee);
        access(1'b0, 32'h0000_0044, 32'd0, er, ee);

        for (int k = 0; k < 8; k++) begin
            a = ($urandom & 32'hFFFF_F000) | (k << 2);
            d = $urandom;
            model(1'b1, a, d, er, ee);
            access(1'b1, a, d, er, ee);
        end
        for (int k = 0; k < 30; k++) begin
            w = 1'($urandom);
            a = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
            d = $urandom;
            model(w, a, d, er, ee);
            access(w, a, d, er, ee);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
